// File: rtl/poly_eval_horner.sv
// Horner-rule polynomial evaluator: one shared multiply/add step sequenced by a go/done FSM.
// Optional overflow tracking is built when POLY_EVAL_OVF_EN is defined; otherwise ovf is tied low.
module poly_eval_horner #(
  parameter int WIDTH   = 8,
  parameter int MAX_DEG = 3,
  localparam int AW     = (MAX_DEG < 1) ? 1 : $clog2(MAX_DEG + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             go,
  input  logic [WIDTH-1:0] x,
  input  logic [AW-1:0]    deg,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             ovf
);

  localparam logic [AW-1:0] MAX_IDX    = AW'(MAX_DEG);
  localparam bit            NEED_CLAMP = ((2 ** AW) != (MAX_DEG + 1));

  // IDLE wait go | INIT acc=c[d] | MUL acc*=x | ADD acc+=c[idx-1] | DONE hold f until go low
  typedef enum logic [2:0] {IDLE, INIT, MUL, ADD, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] coef [MAX_DEG+1];
  logic [WIDTH-1:0] acc, xr, prod, sum;
  logic [AW-1:0]    dr, idx, idx_m1, deg_eff;
  logic             addr_ok;

  assign idx_m1 = idx - AW'(1);

  generate
    if (NEED_CLAMP) begin : g_clamp
      assign deg_eff = (deg > MAX_IDX) ? MAX_IDX : deg;
      assign addr_ok = (coef_addr <= MAX_IDX);
    end else begin : g_no_clamp
      assign deg_eff = deg;
      assign addr_ok = 1'b1;
    end
  endgenerate

`ifdef POLY_EVAL_OVF_EN
  logic [2*WIDTH-1:0] prod_full;
  logic [WIDTH:0]     sum_full;
  logic               ovf_r;

  assign prod_full = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, xr};
  assign sum_full  = {1'b0, acc} + {1'b0, coef[idx_m1]};
  assign prod      = prod_full[WIDTH-1:0];
  assign sum       = sum_full[WIDTH-1:0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovf_r <= 1'b0;
    end else if (state == IDLE && go) begin
      ovf_r <= 1'b0;
    end else if (state == MUL && (|prod_full[2*WIDTH-1:WIDTH])) begin
      ovf_r <= 1'b1;
    end else if (state == ADD && sum_full[WIDTH]) begin
      ovf_r <= 1'b1;
    end
  end

  assign ovf = ovf_r;
`else
  assign prod = acc * xr;
  assign sum  = acc + coef[idx_m1];
  assign ovf  = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = INIT;
      INIT:    state_nxt = (dr == '0) ? DONE : MUL;
      MUL:     state_nxt = ADD;
      ADD:     state_nxt = (idx_m1 == '0) ? DONE : MUL;
      DONE:    if (!go) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i <= MAX_DEG; i++) coef[i] <= '0;
      acc <= '0;
      xr  <= '0;
      dr  <= '0;
      idx <= '0;
      f   <= '0;
    end else begin
      // Bank is frozen while a run is in flight so the result stays consistent.
      if (coef_we && addr_ok && (state == IDLE || state == DONE))
        coef[coef_addr] <= coef_data;
      case (state)
        IDLE: if (go) begin
          xr <= x;
          dr <= deg_eff;
        end
        INIT: begin
          acc <= coef[dr];
          idx <= dr;
          if (dr == '0) f <= coef[dr];
        end
        MUL: acc <= prod;
        ADD: begin
          acc <= sum;
          idx <= idx_m1;
          if (idx_m1 == '0) f <= sum;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == INIT) || (state == MUL) || (state == ADD);
  assign done = (state == DONE);

endmodule
